// File: rtl/text_row_fetcher.sv
// Fetches one display row of char/attr cells from SDRAM into a double-buffered line buffer, applying the scroll offset.
// Optional late-fetch detection under TEXT_FETCH_UNDERRUN_EN; lb_cell has 1-cycle latency, fetch_done lands 2 cycles after the last rd_done.
module text_row_fetcher #(
  parameter int         COLUMNS       = 80,
  parameter int         ROWS          = 51,
  parameter int         BURST_LEN     = 16,
  parameter logic [3:0] FIRST_ROW_REG = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  register_index,
  input  logic [22:0] register_value,
  input  logic        fetch_start,
  input  logic [5:0]  fetch_row,
  output logic        busy,
  output logic        fetch_done,
  output logic [22:0] rd_address,
  output logic        rd_request,
  output logic [8:0]  rd_burst_length,
  input  logic [31:0] rd_data,
  input  logic        rd_data_valid,
  input  logic        rd_done,
  input  logic        line_swap,
  input  logic [6:0]  lb_index,
  output logic [31:0] lb_cell,
  output logic        underrun
);

  localparam logic [6:0] ROWS_W  = 7'(ROWS);
  localparam logic [6:0] COLS_W  = 7'(COLUMNS);
  localparam logic [6:0] BURST_W = 7'(BURST_LEN);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQUEST = 2'd1;
  localparam logic [1:0] RECEIVE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]  state;
  logic [5:0]  first_row;
  logic [5:0]  phys;
  logic [6:0]  count;
  logic [6:0]  burst_count;
  logic        back_sel;
  logic        front_sel;
  logic [31:0] bank0 [COLUMNS];
  logic [31:0] bank1 [COLUMNS];

  logic [6:0]  row_sum;
  logic [6:0]  row_wrap;
  logic [5:0]  row_phys;
  logic        row_valid;
  logic        word_accept;
  logic [6:0]  count_next;
  logic        unused_bits;

  // Scroll map: display row plus first row, wrapped once around the circular page.
  assign row_sum     = {1'b0, fetch_row} + {1'b0, first_row};
  assign row_wrap    = row_sum - ROWS_W;
  assign row_phys    = (row_sum >= ROWS_W) ? row_wrap[5:0] : row_sum[5:0];
  assign row_valid   = ({1'b0, fetch_row} < ROWS_W);
  assign word_accept = (state == RECEIVE) && rd_data_valid && (burst_count < BURST_W);
  assign count_next  = word_accept ? count + 7'd1 : count;
  assign unused_bits = ^{register_value[22:15], register_value[8:0], row_wrap[6]};

  assign busy            = (state == REQUEST) || (state == RECEIVE);
  assign rd_request      = (state == REQUEST);
  assign rd_address      = {8'b0, phys, 9'b0} + {14'b0, count, 2'b00};
  assign rd_burst_length = 9'(BURST_LEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      first_row   <= 6'd0;
      phys        <= 6'd0;
      count       <= 7'd0;
      burst_count <= 7'd0;
      back_sel    <= 1'b0;
      front_sel   <= 1'b0;
      fetch_done  <= 1'b0;
    end else begin
      if (register_index == FIRST_ROW_REG)
        first_row <= register_value[14:9];
      if (line_swap)
        front_sel <= ~front_sel;
      // Registered so both normal and out-of-range completions come from one flop.
      fetch_done <= (state == DONE) || ((state == IDLE) && fetch_start && !row_valid);
      case (state)
        IDLE: begin
          if (fetch_start && row_valid) begin
            phys     <= row_phys;
            count    <= 7'd0;
            back_sel <= ~front_sel;
            state    <= REQUEST;
          end
        end
        REQUEST: begin
          burst_count <= 7'd0;
          state       <= RECEIVE;
        end
        RECEIVE: begin
          count <= count_next;
          if (word_accept)
            burst_count <= burst_count + 7'd1;
          if (rd_done)
            state <= (count_next == COLS_W) ? DONE : REQUEST;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && word_accept && (count < COLS_W)) begin
      if (back_sel)
        bank1[count] <= rd_data;
      else
        bank0[count] <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      lb_cell <= 32'd0;
    else if (lb_index < COLS_W)
      lb_cell <= front_sel ? bank1[lb_index] : bank0[lb_index];
    else
      lb_cell <= 32'd0;
  end

`ifdef TEXT_FETCH_UNDERRUN_EN
  always_ff @(posedge clk) begin
    if (reset)
      underrun <= 1'b0;
    else if (line_swap && busy)
      underrun <= 1'b1;
  end
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_text_row_fetcher.sv
// Directed bench for text_row_fetcher: fetch vector table, line buffer read table, multi-cycle corner sequences.
module tb_text_row_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  register_index = 4'd0;
  logic [22:0] register_value = 23'd0;
  logic        fetch_start = 1'b0;
  logic [5:0]  fetch_row = 6'd0;
  logic        busy;
  logic        fetch_done;
  logic [22:0] rd_address;
  logic        rd_request;
  logic [8:0]  rd_burst_length;
  logic [31:0] rd_data = 32'd0;
  logic        rd_data_valid = 1'b0;
  logic        rd_done = 1'b0;
  logic        line_swap = 1'b0;
  logic [6:0]  lb_index = 7'd0;
  logic [31:0] lb_cell;
  logic        underrun;

  int tests = 0;
  int failed = 0;

  text_row_fetcher dut (
    .clk(clk), .reset(reset),
    .register_index(register_index), .register_value(register_value),
    .fetch_start(fetch_start), .fetch_row(fetch_row),
    .busy(busy), .fetch_done(fetch_done),
    .rd_address(rd_address), .rd_request(rd_request), .rd_burst_length(rd_burst_length),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_done(rd_done),
    .line_swap(line_swap), .lb_index(lb_index), .lb_cell(lb_cell), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  fr;
    logic [5:0]  row;
    logic [22:0] base;
    logic [31:0] seed;
  } fetch_vec_t;

  typedef struct {
    logic [6:0]  idx;
    logic [31:0] exp;
  } lb_vec_t;

  fetch_vec_t fv[5];
  lb_vec_t    lv[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_first_row(input logic [5:0] fr);
    register_index = 4'd1;
    register_value = {8'b0, fr, 9'b0};
    tick();
    register_index = 4'd0;
    register_value = 23'd0;
  endtask

  task automatic pulse_swap();
    line_swap = 1'b1;
    tick();
    line_swap = 1'b0;
  endtask

  task automatic read_lb(input logic [6:0] idx, input logic [31:0] exp, input string name);
    lb_index = idx;
    tick();
    check(name, lb_cell, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " fetch_done"}, fetch_done, 0);
    check({tag, " rd_request"}, rd_request, 0);
    check({tag, " rd_address"}, rd_address, 0);
    check({tag, " rd_burst_length"}, rd_burst_length, 16);
    check({tag, " lb_cell"}, lb_cell, 0);
    check({tag, " underrun"}, underrun, 0);
  endtask

  // Full 80-cell fetch; word n of the row carries seed+n.
  task automatic do_fetch(input logic [5:0] row, input logic [22:0] base, input logic [31:0] seed,
                          input bit mid_change, input logic [5:0] new_fr, input bit extra_word);
    int n;
    int words;
    fetch_row   = row;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("busy during fetch", busy, 1);
    for (int b = 0; b < 5; b++) begin
      n = 0;
      while (!rd_request && n < 8) begin
        tick();
        n++;
      end
      check("rd_request", rd_request, 1);
      check("rd_address", rd_address, {9'b0, base} + 32'(b * 64));
      tick();
      check("rd_request one cycle", rd_request, 0);
      words = (extra_word && b == 0) ? 17 : 16;
      for (int w = 0; w < words; w++) begin
        rd_data_valid = 1'b1;
        rd_data = (w == 16) ? 32'hDEAD_BEEF : seed + 32'(b * 16 + w);
        if (mid_change && b == 0 && w == 0) begin
          register_index = 4'd1;
          register_value = {8'b0, new_fr, 9'b0};
        end else begin
          register_index = 4'd0;
        end
        tick();
      end
      rd_data_valid = 1'b0;
      register_index = 4'd0;
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
    end
    check("fetch_done early", fetch_done, 0);
    tick();
    check("fetch_done", fetch_done, 1);
    check("busy after done", busy, 0);
    tick();
    check("fetch_done one cycle", fetch_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    fv[0] = '{fr: 6'd0,  row: 6'd0,  base: 23'h000,  seed: 32'h0000_1000};
    fv[1] = '{fr: 6'd50, row: 6'd3,  base: 23'h400,  seed: 32'h0000_2000};
    fv[2] = '{fr: 6'd10, row: 6'd40, base: 23'h6400, seed: 32'h0000_3000};
    fv[3] = '{fr: 6'd20, row: 6'd31, base: 23'h000,  seed: 32'h0000_4000};
    fv[4] = '{fr: 6'd0,  row: 6'd7,  base: 23'hE00,  seed: 32'h0000_0000};
    lv[0] = '{idx: 7'd0,   exp: 32'd0};
    lv[1] = '{idx: 7'd1,   exp: 32'd1};
    lv[2] = '{idx: 7'd42,  exp: 32'd42};
    lv[3] = '{idx: 7'd79,  exp: 32'd79};
    lv[4] = '{idx: 7'd80,  exp: 32'd0};
    lv[5] = '{idx: 7'd127, exp: 32'd0};

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_values("reset");

    for (int i = 0; i < 5; i++) begin
      set_first_row(fv[i].fr);
      do_fetch(fv[i].row, fv[i].base, fv[i].seed, 1'b0, 6'd0, 1'b0);
    end

    // Last table fetch (row 7, cell i = i) sits in the back bank; bring it to the front.
    pulse_swap();
    for (int i = 0; i < 6; i++)
      read_lb(lv[i].idx, lv[i].exp, "lb_cell table");

    // first_row change mid-fetch only affects the next fetch.
    do_fetch(6'd5, 23'hA00, 32'h0000_6000, 1'b1, 6'd1, 1'b0);
    do_fetch(6'd5, 23'hC00, 32'h0000_6000, 1'b0, 6'd0, 1'b0);

    // 17th word of a burst is dropped; second burst address proves count stopped at 16.
    do_fetch(6'd0, 23'h200, 32'h0000_7000, 1'b0, 6'd0, 1'b1);
    pulse_swap();
    read_lb(7'd15, 32'h0000_700F, "cell15 after overrun burst");
    read_lb(7'd16, 32'h0000_7010, "cell16 after overrun burst");
    read_lb(7'd17, 32'h0000_7011, "cell17 after overrun burst");

    // Out-of-range row: no SDRAM traffic, fetch_done the next cycle, back bank untouched.
    fetch_row   = 6'd51;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("oor fetch_done", fetch_done, 1);
    check("oor rd_request", rd_request, 0);
    check("oor busy", busy, 0);
    tick();
    check("oor fetch_done one cycle", fetch_done, 0);
    check("oor rd_request later", rd_request, 0);
    pulse_swap();
    read_lb(7'd79, 32'd79, "back bank untouched");
    check("underrun before late swap", underrun, 0);

    // Late swap during a fetch, then reset while receiving.
    set_first_row(6'd0);
    fetch_row   = 6'd2;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    pulse_swap();
    for (int w = 0; w < 3; w++) begin
      rd_data_valid = 1'b1;
      rd_data = 32'(w);
      tick();
    end
`ifdef TEXT_FETCH_UNDERRUN_EN
    check("underrun after busy swap", underrun, 1);
`else
    check("underrun after busy swap", underrun, 0);
`endif
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("mid-fetch reset");
    rd_done = 1'b1;
    tick();
    rd_data_valid = 1'b0;
    rd_done = 1'b0;
    check("late rd_done busy", busy, 0);
    check("late rd_done rd_request", rd_request, 0);
    tick();
    check("late rd_done fetch_done", fetch_done, 0);
    do_fetch(6'd0, 23'h000, 32'h0000_5000, 1'b0, 6'd0, 1'b0);
    pulse_swap();
    read_lb(7'd33, 32'h0000_5021, "cell after post-reset fetch");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
